ifft8_seq: RTL and testbench
============================

IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the eight input bins are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a new frame.
REQ-005 SHALL have ports a_re..h_re and a_im..h_im, input, 8 bits signed each: frequency bins X0..X7 in natural order (a=X0 ... h=X7).
REQ-006 SHALL have port out_valid, output, 1 bit: the time-domain frame is valid.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame.
REQ-008 SHALL have ports ifft_a_re..ifft_h_re and ifft_a_im..ifft_h_im, output, 8 bits signed each: samples x0..x7 in natural order.

Function
REQ-009 SHALL compute x[n] = (1/8)·Σ X[k]·e^{+j2πkn/8} for an 8-point radix-2 decimation-in-frequency transform, with each stage scaled by 1/2.
REQ-010 SHALL use FSM states IDLE, STAGE1, STAGE2, STAGE3 and DONE.
REQ-011 SHALL, in IDLE, hold in_ready=1; all other states hold in_ready=0.
REQ-012 SHALL, on in_valid&in_ready at an edge, capture all 16 inputs into the working registers, clear the butterfly counter and enter STAGE1.
REQ-013 SHALL execute exactly one butterfly per clock, four per stage: STAGE1 pairs (k,k+4) with k=0..3; STAGE2 pairs (0,2),(1,3),(4,6),(5,7); STAGE3 pairs (0,1),(2,3),(4,5),(6,7).
REQ-014 SHALL apply the butterfly a'=sat((a+b)>>>1), b'=sat(((a-b)·W)>>>1), where the difference is computed at 9 bits and the result is formed at 11 bits before the shift.
REQ-015 SHALL use these twiddles: STAGE1 W=e^{+jπk/4} for k=0..3; STAGE2 W=1 for the first pair of each half and W=+j for the second; STAGE3 W=1.
REQ-016 SHALL implement W=+j as (re,im)->(-im,re), and W=e^{±jπ/4} terms with constant C=91 (Q0.7) as (C·v)>>>7.
REQ-017 SHALL use floor rounding (arithmetic shift) everywhere and saturate results to [-128,127].
REQ-018 SHALL map working position p to output sample x[bitrev3(p)].
REQ-019 SHALL, after the 12th butterfly edge following acceptance, enter DONE, drive the outputs from the registers and assert out_valid; latency is 12 edges from the accept edge to out_valid=1.
REQ-020 SHALL hold out_valid and all output data stable in DONE until out_ready=1, then return to IDLE at that edge with out_valid=0.
REQ-021 SHALL ignore in_valid while not in IDLE; no frame is queued.
REQ-022 SHALL, when out_ready is high on the same edge out_valid first rises, leave DONE on the next edge (minimum 1 cycle in DONE).

Reset
REQ-023 SHALL, on rst high at any time including mid-transform, asynchronously go to IDLE, clear the counter and working registers, drive out_valid=0 and in_ready=1 after release, and set all ifft_* outputs to 0.
REQ-024 SHALL discard any partially computed frame on reset; nothing is emitted after reset until a new accept.

Structure
REQ-025 SHALL keep the shared package ifft8_pkg containing the sample width (8), internal width (11), C707=91, the stage/state enumeration and the bitrev3 function.
REQ-026 SHALL instantiate exactly one sub-module, ifft8_bfly: a combinational butterfly with inputs a, b, twiddle select and outputs a', b', reused across all 12 cycles.

Verification
REQ-027 SHALL check the impulse case: X0=(64,0), others 0 -> all x[n]=(8,0), out_valid 12 edges after accept.
REQ-028 SHALL check the flat spectrum case: all X=(80,0) -> x0=(80,0), x1..x7=(0,0).
REQ-029 SHALL check single bin X1=(64,0) -> x0=(8,0), x1=(5,5), x2=(0,8), x3=(-6,5), x4=(-8,0), x5=(-6,-6), x6=(0,-8), x7=(5,-6).
REQ-030 SHALL check backpressure: out_ready=0 for 5 cycles after out_valid -> data and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-031 SHALL check in_valid held high during busy with different data -> ignored; the output matches the first frame only.
REQ-032 SHALL check reset at butterfly 6 -> outputs 0, out_valid=0, in_ready=1; the next frame computes correctly.

Source files
------------

// File: rtl/ifft8_pkg.sv
// Shared definitions for the sequential 8-point IFFT: widths, twiddle constant,
// FSM and twiddle-select encodings, complex sample type and the bit-reverse helper.
// No logic; imported by ifft8_bfly and ifft8_seq.
package ifft8_pkg;

   localparam int SW   = 8;    // sample width (in/out)
   localparam int IW   = 11;   // internal butterfly width before the final shift
   localparam int C707 = 91;   // cos(pi/4) in Q0.7

   typedef enum logic [2:0] {
      IDLE,
      STAGE1,
      STAGE2,
      STAGE3,
      DONE
   } state_t;

   // Twiddle select: W = e^{+j*pi*k/4}, k = 0..3
   typedef enum logic [1:0] {
      TW_ONE,
      TW_E1,
      TW_J,
      TW_E3
   } tw_t;

   typedef struct packed {
      logic [SW-1:0] re;
      logic [SW-1:0] im;
   } cplx_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] p);
      return {p[0], p[1], p[2]};
   endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 DIF butterfly: a_out = sat((a+b)>>>1), b_out = sat(((a-b)*W)>>>1).
// Zero latency; no flow control (pure function of a, b, tw).
// Ports: a, b complex inputs; tw twiddle select; a_out, b_out complex results.
module ifft8_bfly
   import ifft8_pkg::*;
(
   input  cplx_t a,
   input  cplx_t b,
   input  tw_t   tw,
   output cplx_t a_out,
   output cplx_t b_out
);

   localparam logic signed [IW-1:0] MAXV = IW'(127);
   localparam logic signed [IW-1:0] MINV = IW'(-128);
   localparam logic [IW+7:0]        CK   = (IW+8)'(C707);

   function automatic logic signed [IW-1:0] ext9(input logic signed [8:0] v);
      return {{(IW-9){v[8]}}, v};
   endfunction

   // (C*v)>>>7 with floor rounding; taking the upper bits of the product
   // is the arithmetic shift.
   function automatic logic signed [IW-1:0] mul_c(input logic signed [IW-1:0] v);
      logic [IW+7:0] p;
      p = {{8{v[IW-1]}}, v} * CK;
      return p[IW+6:7];
   endfunction

   function automatic logic [SW-1:0] sat8(input logic signed [IW-1:0] v);
      if (v > MAXV)
         return 8'h7F;
      else if (v < MINV)
         return 8'h80;
      else
         return v[SW-1:0];
   endfunction

   logic signed [8:0]    sum_re, sum_im, dif_re, dif_im;
   logic signed [IW-1:0] dre, dim, t_re, t_im;

   always_comb begin
      sum_re = {a.re[SW-1], a.re} + {b.re[SW-1], b.re};
      sum_im = {a.im[SW-1], a.im} + {b.im[SW-1], b.im};
      dif_re = {a.re[SW-1], a.re} - {b.re[SW-1], b.re};
      dif_im = {a.im[SW-1], a.im} - {b.im[SW-1], b.im};
      dre    = ext9(dif_re);
      dim    = ext9(dif_im);
      t_re   = dre;
      t_im   = dim;
      case (tw)
         TW_ONE: begin
            t_re = dre;
            t_im = dim;
         end
         // (1+j)/sqrt2 : (C(re-im), C(re+im))
         TW_E1: begin
            t_re = mul_c(dre - dim);
            t_im = mul_c(dre + dim);
         end
         TW_J: begin
            t_re = -dim;
            t_im = dre;
         end
         // (-1+j)/sqrt2 : (C(-re-im), C(re-im))
         TW_E3: begin
            t_re = mul_c(-dre - dim);
            t_im = mul_c(dre - dim);
         end
         default: begin
            t_re = dre;
            t_im = dim;
         end
      endcase
      a_out.re = sat8(ext9(sum_re) >>> 1);
      a_out.im = sat8(ext9(sum_im) >>> 1);
      b_out.re = sat8(t_re >>> 1);
      b_out.im = sat8(t_im >>> 1);
   end

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point IFFT (radix-2 DIF, 1/2 scaling per stage), one butterfly per clock.
// Latency: 12 edges from accept to out_valid; in_ready only in IDLE, new frames are not queued.
// Backpressure: result held stable in DONE until out_ready; ports a..h = X0..X7 in, ifft_a..h = x0..x7 out.
module ifft8_seq
   import ifft8_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [SW-1:0] a_re, b_re, c_re, d_re, e_re, f_re, g_re, h_re,
   input  logic signed [SW-1:0] a_im, b_im, c_im, d_im, e_im, f_im, g_im, h_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [SW-1:0] ifft_a_re, ifft_b_re, ifft_c_re, ifft_d_re,
   output logic signed [SW-1:0] ifft_e_re, ifft_f_re, ifft_g_re, ifft_h_re,
   output logic signed [SW-1:0] ifft_a_im, ifft_b_im, ifft_c_im, ifft_d_im,
   output logic signed [SW-1:0] ifft_e_im, ifft_f_im, ifft_g_im, ifft_h_im
);

   state_t     state;
   logic [1:0] cnt;
   cplx_t      work [8];
   logic [2:0] idx_a, idx_b;
   tw_t        tw;
   cplx_t      bf_a, bf_b, bf_a_out, bf_b_out;

   // Butterfly operand addressing; cnt walks the four pairs of each stage.
   always_comb begin
      idx_a = 3'd0;
      idx_b = 3'd0;
      tw    = TW_ONE;
      case (state)
         STAGE1: begin
            idx_a = {1'b0, cnt};
            idx_b = {1'b1, cnt};
            tw    = tw_t'(cnt);
         end
         STAGE2: begin
            idx_a = {cnt[1], 1'b0, cnt[0]};
            idx_b = {cnt[1], 1'b1, cnt[0]};
            tw    = cnt[0] ? TW_J : TW_ONE;
         end
         STAGE3: begin
            idx_a = {cnt, 1'b0};
            idx_b = {cnt, 1'b1};
         end
         default: ;
      endcase
   end

   assign bf_a = work[idx_a];
   assign bf_b = work[idx_b];

   ifft8_bfly u_bfly (
      .a     (bf_a),
      .b     (bf_b),
      .tw    (tw),
      .a_out (bf_a_out),
      .b_out (bf_b_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < 8; i++)
            work[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work[0]  <= '{re: a_re, im: a_im};
                  work[1]  <= '{re: b_re, im: b_im};
                  work[2]  <= '{re: c_re, im: c_im};
                  work[3]  <= '{re: d_re, im: d_im};
                  work[4]  <= '{re: e_re, im: e_im};
                  work[5]  <= '{re: f_re, im: f_im};
                  work[6]  <= '{re: g_re, im: g_im};
                  work[7]  <= '{re: h_re, im: h_im};
                  cnt      <= 2'd0;
                  in_ready <= 1'b0;
                  state    <= STAGE1;
               end
            end
            STAGE1, STAGE2, STAGE3: begin
               work[idx_a] <= bf_a_out;
               work[idx_b] <= bf_b_out;
               cnt         <= cnt + 2'd1;   // wraps to 0 for the next stage
               if (cnt == 2'd3) begin
                  case (state)
                     STAGE1:  state <= STAGE2;
                     STAGE2:  state <= STAGE3;
                     default: begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                     end
                  endcase
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // DIF leaves results in bit-reversed order: x[n] lives at work[bitrev3(n)].
   assign ifft_a_re = work[bitrev3(3'd0)].re;
   assign ifft_b_re = work[bitrev3(3'd1)].re;
   assign ifft_c_re = work[bitrev3(3'd2)].re;
   assign ifft_d_re = work[bitrev3(3'd3)].re;
   assign ifft_e_re = work[bitrev3(3'd4)].re;
   assign ifft_f_re = work[bitrev3(3'd5)].re;
   assign ifft_g_re = work[bitrev3(3'd6)].re;
   assign ifft_h_re = work[bitrev3(3'd7)].re;
   assign ifft_a_im = work[bitrev3(3'd0)].im;
   assign ifft_b_im = work[bitrev3(3'd1)].im;
   assign ifft_c_im = work[bitrev3(3'd2)].im;
   assign ifft_d_im = work[bitrev3(3'd3)].im;
   assign ifft_e_im = work[bitrev3(3'd4)].im;
   assign ifft_f_im = work[bitrev3(3'd5)].im;
   assign ifft_g_im = work[bitrev3(3'd6)].im;
   assign ifft_h_im = work[bitrev3(3'd7)].im;

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq with an integer reference IFFT model and a per-cycle compare.
// Covers impulse, flat, single-bin, saturating frames, backpressure, busy-time in_valid and mid-run reset.
// Inputs driven #1 after posedge, outputs sampled on negedge.
module tb_ifft8_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [7:0][7:0] in_re = '0;
   logic [7:0][7:0] in_im = '0;
   wire  [7:0][7:0] o_re;
   wire  [7:0][7:0] o_im;
   wire  in_ready, out_valid;

   int total = 0;
   int bad = 0;
   int exp_re [8];
   int exp_im [8];
   int m_re [8];
   int m_im [8];
   bit exp_armed = 1'b0;

   always #5 clk = ~clk;

   ifft8_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(in_re[0]), .b_re(in_re[1]), .c_re(in_re[2]), .d_re(in_re[3]),
      .e_re(in_re[4]), .f_re(in_re[5]), .g_re(in_re[6]), .h_re(in_re[7]),
      .a_im(in_im[0]), .b_im(in_im[1]), .c_im(in_im[2]), .d_im(in_im[3]),
      .e_im(in_im[4]), .f_im(in_im[5]), .g_im(in_im[6]), .h_im(in_im[7]),
      .out_valid(out_valid), .out_ready(out_ready),
      .ifft_a_re(o_re[0]), .ifft_b_re(o_re[1]), .ifft_c_re(o_re[2]), .ifft_d_re(o_re[3]),
      .ifft_e_re(o_re[4]), .ifft_f_re(o_re[5]), .ifft_g_re(o_re[6]), .ifft_h_re(o_re[7]),
      .ifft_a_im(o_im[0]), .ifft_b_im(o_im[1]), .ifft_c_im(o_im[2]), .ifft_d_im(o_im[3]),
      .ifft_e_im(o_im[4]), .ifft_f_im(o_im[5]), .ifft_g_im(o_im[6]), .ifft_h_im(o_im[7])
   );

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, want);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int br3(input int p);
      return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
   endfunction

   // Reference: textbook DIF, twiddle as a Q7 complex multiply, floor shifts,
   // then bit-reversed readout. Operates in place on m_re/m_im.
   task automatic model_run();
      int wr [4] = '{128, 91, 0, -91};
      int wi [4] = '{0, 91, 128, 91};
      int t_re [8];
      int t_im [8];
      for (int s = 0; s < 3; s++) begin
         int span;
         span = 4 >> s;
         for (int base = 0; base < 8; base += 2 * span) begin
            for (int k = 0; k < span; k++) begin
               int i, j, e, dr, di, pr, pi, sr, si;
               i  = base + k;
               j  = i + span;
               e  = k << s;
               sr = m_re[i] + m_re[j];
               si = m_im[i] + m_im[j];
               dr = m_re[i] - m_re[j];
               di = m_im[i] - m_im[j];
               pr = (wr[e] * dr - wi[e] * di) >>> 7;
               pi = (wr[e] * di + wi[e] * dr) >>> 7;
               m_re[i] = sat(sr >>> 1);
               m_im[i] = sat(si >>> 1);
               m_re[j] = sat(pr >>> 1);
               m_im[j] = sat(pi >>> 1);
            end
         end
      end
      for (int p = 0; p < 8; p++) begin
         t_re[br3(p)] = m_re[p];
         t_im[br3(p)] = m_im[p];
      end
      for (int n = 0; n < 8; n++) begin
         m_re[n] = t_re[n];
         m_im[n] = t_im[n];
      end
   endtask

   task automatic load_vec(input int id);
      int vr [8];
      int vi [8];
      vr = '{default: 0};
      vi = '{default: 0};
      case (id)
         0: vr[0] = 64;
         1: vr = '{default: 80};
         2: vr[1] = 64;
         3: begin
            vr = '{127, -128, 100, -7, -128, 127, 55, -1};
            vi = '{-128, 127, -50, 33, -128, 127, -99, 1};
         end
         4: begin
            vr = '{default: -50};
            vi = '{default: 30};
         end
         default: begin
            vr = '{10, 30, -60, 7, -1, 90, 0, -128};
            vi = '{-20, 40, 5, 7, -2, -90, 100, 0};
         end
      endcase
      for (int n = 0; n < 8; n++) begin
         in_re[n] = 8'(vr[n]);
         in_im[n] = 8'(vi[n]);
         m_re[n]  = vr[n];
         m_im[n]  = vi[n];
      end
   endtask

   task automatic chk_zero_out(input string tag);
      for (int n = 0; n < 8; n++) begin
         chk($sformatf("%s_x%0d_re", tag, n), int'($signed(o_re[n])), 0);
         chk($sformatf("%s_x%0d_im", tag, n), int'($signed(o_im[n])), 0);
      end
   endtask

   // One frame: accept, measure latency, optional backpressure, release.
   task automatic run_frame(input int id, input int hold, input bit early_rdy, input bit flood);
      int lat;
      load_vec(id);
      model_run();
      for (int n = 0; n < 8; n++) begin
         exp_re[n] = m_re[n];
         exp_im[n] = m_im[n];
      end
      chk("in_ready_idle", int'(in_ready), 1);
      in_valid  = 1'b1;
      out_ready = early_rdy;
      @(posedge clk);
      #1;
      exp_armed = 1'b1;
      chk("in_ready_after_accept", int'(in_ready), 0);
      if (flood)
         load_vec(4);
      else
         in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("latency", lat, 12);
      if (early_rdy) begin
         @(posedge clk);
         #1;
         chk("done_one_cycle", int'(out_valid), 0);
      end else begin
         for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         chk("release_valid", int'(out_valid), 0);
      end
      chk("release_in_ready", int'(in_ready), 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_armed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Every cycle with out_valid: data must equal the model, in_ready low.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!exp_armed) begin
            chk("spurious_valid", int'(out_valid), 0);
         end else begin
            for (int n = 0; n < 8; n++) begin
               chk($sformatf("x%0d_re", n), int'($signed(o_re[n])), exp_re[n]);
               chk($sformatf("x%0d_im", n), int'($signed(o_im[n])), exp_im[n]);
            end
            chk("in_ready_in_done", int'(in_ready), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      int lit_re [8];
      int lit_im [8];

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk_zero_out("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid_rel", int'(out_valid), 0);

      // Pin the model to hand-computed results
      load_vec(0);
      model_run();
      for (int n = 0; n < 8; n++) begin
         chk("pin_imp_re", m_re[n], 8);
         chk("pin_imp_im", m_im[n], 0);
      end
      load_vec(1);
      model_run();
      for (int n = 0; n < 8; n++) begin
         chk("pin_flat_re", m_re[n], (n == 0) ? 80 : 0);
         chk("pin_flat_im", m_im[n], 0);
      end
      lit_re = '{8, 5, 0, -6, -8, -6, 0, 5};
      lit_im = '{0, 5, 8, 5, 0, -6, -8, -6};
      load_vec(2);
      model_run();
      for (int n = 0; n < 8; n++) begin
         chk("pin_bin1_re", m_re[n], lit_re[n]);
         chk("pin_bin1_im", m_im[n], lit_im[n]);
      end

      // Frames against the DUT
      run_frame(0, 0, 1'b1, 1'b0);   // impulse, out_ready already high
      run_frame(1, 2, 1'b0, 1'b0);   // flat spectrum
      run_frame(2, 5, 1'b0, 1'b0);   // single bin, 5 cycles of backpressure
      run_frame(3, 1, 1'b0, 1'b0);   // saturating mixed values
      run_frame(5, 0, 1'b0, 1'b1);   // in_valid held high with other data while busy

      // Reset after the 6th butterfly
      load_vec(3);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk_zero_out("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid_rel", int'(out_valid), 0);
      repeat (20) @(posedge clk);
      #1;
      run_frame(5, 1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
